// File: rtl/uart_rx_fsm.sv
`timescale 1ns/1ps
// uart_rx_fsm
// 8N1 serial receiver. The line is oversampled on clk, and each bit is
// sampled at its midpoint. A good byte is placed in a one-deep valid/ready
// output buffer. Stop-bit errors and buffer overruns are flagged with
// single-cycle pulses.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   rx         serial line, idle high, asynchronous to clk
//   ready      downstream accepts data_out when valid && ready
//   data_out   received byte
//   valid      data_out holds an unconsumed byte
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: good byte dropped, buffer was full
//   busy       high whenever the FSM is not idle
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | line idle, waiting for a falling edge on rx_s
// S_START   | confirming the start bit at its midpoint
// S_DATA    | sampling 8 data bits LSB first, one per bit period
// S_STOP    | sampling the stop bit, then delivering the byte or flagging an error
// S_WAIT_HI | framing error seen, waiting for the line to return high
module uart_rx_fsm #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       ready,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sh;
    logic          rx_meta;
    logic          rx_s;

    // Both flops reset high so that reset release never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= 3'd0;
            sh        <= 8'h00;
            data_out  <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // A consume is overridden below if a delivery lands in the same cycle.
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    idx <= 3'd0;
                    if (!rx_s) begin
                        state <= S_START;
                        busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= S_DATA;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        sh  <= {rx_s, sh[7:1]};
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Back to idle at mid-stop so a back-to-back start bit is caught.
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            if (!valid || ready) begin
                                data_out <= sh;
                                valid    <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_WAIT_HI;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_WAIT_HI: begin
                    // A held-low (break) line must not restart a frame.
                    if (rx_s) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Serial receiver that consumes the line driven by the team's UART transmitter. It recovers 8N1 frames from an asynchronous `rx` pin by oversampling on the system clock and samples each bit at its midpoint. Each good byte is presented on a one-deep valid/ready output buffer to downstream logic. The block also flags framing errors and buffer overruns.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per bit period (N). Legal range is ≥ 4. Half-bit H = N/2, integer division.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `rx`  input  1  serial line, idle-high, asynchronous to `clk`.
- `ready`  input  1  downstream accepts `data_out` when `valid && ready`.
- `data_out`  output  8  received byte.
- `valid`  output  1  `data_out` holds an unconsumed byte.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `overrun`  output  1  one-cycle pulse: good byte dropped because the buffer was full.
- `busy`  output  1  high whenever state ≠ IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1. All decisions use `rx_s`.
- Counter `cnt` has width clog2(N). Bit index `idx` is 3 bits. Shift register `sh` is 8 bits, and bits are received LSB first.
- State machine, 5 states:
  - IDLE: `cnt`=0, `idx`=0. If `rx_s`==0, go to START.
  - START: `cnt` increments. When `cnt`==H-1: if `rx_s`==0, go to DATA with `cnt`=0; else it was a false start, go to IDLE.
  - DATA: `cnt` increments. When `cnt`==N-1: `sh` <= {`rx_s`, `sh`[7:1]}, `cnt`=0, `idx`++. After the sample with `idx`==7, go to STOP.
  - STOP: `cnt` increments. When `cnt`==N-1, sample `rx_s`:
    - If 1, deliver `sh` to the output buffer and go to IDLE.
    - If 0, pulse `frame_err`, discard `sh`, and go to WAIT_HI.
  - WAIT_HI: stay until `rx_s`==1, then go to IDLE. This prevents a held-low line (break) from re-triggering.
- Output buffer:
  - Consume: `valid && ready` clears `valid` on the next edge.
  - Deliver when `valid`==0, or when a consume happens in the same cycle: `data_out` <= `sh`, `valid` <= 1. A simultaneous consume and deliver leaves `valid` at 1 with the new data.
  - Deliver when `valid`==1 and `ready`==0: the new byte is dropped, `overrun` pulses, and `data_out` is unchanged.
  - `data_out` is stable while `valid`==1 and no deliver occurs.
- `frame_err` and `overrun` are registered. Each is high for exactly one cycle per event.
- Reset asserted at any point: all state is forced immediately, and any partial frame is lost. After release, the FSM is in IDLE and a new start edge is required.

## Timing
- Reset values: `data_out`=8'h00, `valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, state=IDLE, `cnt`=0, `idx`=0, `sh`=0.
- Synchronizer latency: 2 cycles from `rx` pin to `rx_s`.
- Let cycle 0 be the edge at which IDLE sees `rx_s`==0. Then:
  - START is checked at cycle H.
  - Data bit k (k = 0..7) is sampled at cycle H + (k+1)·N.
  - The stop bit is sampled at cycle H + 9N.
  - `valid`, `frame_err` or `overrun` becomes visible from cycle H + 9N + 1.
- FSM returns to IDLE at mid-stop, so a start bit arriving N/2 cycles later is caught. Back-to-back frames are supported with no gap.
- `busy` rises the cycle after cycle 0 and falls with the return to IDLE, or at WAIT_HI exit.
- Tolerance: the sampling point drifts by at most ±1 clk per bit relative to an ideal transmitter running at the same N.

## Test plan
- N=16, `ready`=1, send 0xA5 (line 0,1,0,1,0,0,1,0,1,1) → `valid` high for 1 cycle at pin-edge+2+153, with `data_out`=8'hA5; `frame_err`=0.
- Drive `rx` low for 4 cycles then high → no `valid`; `busy` drops at cycle H+1; the FSM returns to IDLE and the next 0x3C frame is received correctly.
- Send 0x55 with the stop bit driven 0 and the line then held low for 40 cycles → `frame_err` single pulse, `valid` stays 0, `busy` stays 1 until `rx_s` returns to 1, and the following 0x81 frame is received correctly.
- `ready`=0, send 0x11 then 0x22 → `data_out`=8'h11 with `valid`=1, and `overrun` pulses once at the second stop. After raising `ready` for 1 cycle, `valid`=0.
- `ready`=1, three back-to-back frames 0x00, 0xFF, 0x7E with no idle gap → three `valid` pulses exactly 10N cycles apart, with data in order.
- Assert `reset` (low) at the middle of data bit 4 of 0x99, release it, then send 0x42 → all outputs hold reset values during reset, and only 0x42 appears on `data_out`.
